// File: rtl/lia_slice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lia_slice_scheduler                                              |
// | Brief   : Round-robin time-shared slice/saturate stage for NCH sources.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lia_slice_scheduler #(
  parameter int NCH  = 4,
  parameter int WIN  = 64,
  parameter int WOUT = 32,
  parameter int SW   = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          req_i,
  input  logic [NCH*WIN-1:0]      data_i,
  input  logic [NCH*SW-1:0]       shift_i,
  output logic [NCH-1:0]          ack_o,
  output logic [WOUT-1:0]         out_o,
  output logic [$clog2(NCH)-1:0]  out_ch_o,
  output logic                    out_valid_o,
  output logic [NCH-1:0]          ovf_o,
  input  logic [NCH-1:0]          ovf_clr_i
);

  localparam int             CW        = $clog2(NCH);
  localparam logic [SW-1:0]  c_max_sh  = SW'(WIN - WOUT);
  localparam logic [WOUT-1:0] c_sat_max = {1'b0, {(WOUT-1){1'b1}}};
  localparam logic [WOUT-1:0] c_sat_min = {1'b1, {(WOUT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_sel;
  logic [WIN-1:0]  r_data;
  logic [SW-1:0]   r_shift;
  logic [WOUT-1:0] r_out;
  logic [CW-1:0]   r_out_ch;
  logic            r_out_valid;
  logic [NCH-1:0]  r_ovf;

  logic            w_found;
  logic [CW-1:0]   w_win;
  logic            w_cap_ok;
  logic [NCH-1:0]  w_ack;
  logic [SW-1:0]   w_sh_in;
  logic [SW-1:0]   w_eff_sh;
  logic signed [WIN-1:0] w_shifted;
  logic [WIN-WOUT:0] w_hi;
  logic            w_in_range;
  logic [WOUT-1:0] w_sat;
  logic [NCH-1:0]  w_set;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_found && req_i[(int'(r_ptr) + i) % NCH]) begin
        w_found = 1'b1;
        w_win   = CW'((int'(r_ptr) + i) % NCH);
      end
    end
  end

  assign w_cap_ok = (r_state == CAP) && req_i[r_sel] && !rst_i;

  always_comb begin
    w_ack = '0;
    if (w_cap_ok) begin
      w_ack[r_sel] = 1'b1;
    end
  end

  assign w_sh_in  = shift_i[int'(r_sel)*SW +: SW];
  assign w_eff_sh = (w_sh_in > c_max_sh) ? c_max_sh : w_sh_in;

  // The shifted word fits iff every bit from WOUT-1 upward equals the sign.
  assign w_shifted  = $signed(r_data) >>> r_shift;
  assign w_hi       = w_shifted[WIN-1:WOUT-1];
  assign w_in_range = (&w_hi) || (~|w_hi);
  assign w_sat      = w_in_range ? w_shifted[WOUT-1:0]
                    : (w_shifted[WIN-1] ? c_sat_min : c_sat_max);

  always_comb begin
    w_set = '0;
    if ((r_state == SAT) && !w_in_range) begin
      w_set[r_sel] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = CAP;
      CAP:     w_state_nxt = req_i[r_sel] ? SAT : IDLE;
      SAT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= CW'(NCH - 1);
      r_sel       <= '0;
      r_data      <= '0;
      r_shift     <= '0;
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      if ((r_state == IDLE) && w_found) begin
        r_sel <= w_win;
      end
      if (w_cap_ok) begin
        r_data  <= data_i[int'(r_sel)*WIN +: WIN];
        r_shift <= w_eff_sh;
        r_ptr   <= r_sel;
      end
      if (r_state == SAT) begin
        r_out       <= w_sat;
        r_out_ch    <= r_sel;
        r_out_valid <= 1'b1;
      end
      // Set takes priority over a simultaneous clear.
      r_ovf <= (r_ovf & ~ovf_clr_i) | w_set;
    end
  end

  assign ack_o       = w_ack;
  assign out_o       = r_out;
  assign out_ch_o    = r_out_ch;
  assign out_valid_o = r_out_valid;
  assign ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lia_slice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lia_slice_scheduler                                           |
// | Brief   : Directed + random bench with a behavioural reference model.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_lia_slice_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [255:0] data;
  logic [23:0]  shift;
  logic [3:0]   clr;
  logic [3:0]   ack_o;
  logic [31:0]  out_o;
  logic [1:0]   out_ch_o;
  logic         out_valid_o;
  logic [3:0]   ovf_o;

  always #5 clk = ~clk;

  lia_slice_scheduler #(.NCH(4), .WIN(64), .WOUT(32), .SW(6)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .shift_i(shift),
    .ack_o(ack_o), .out_o(out_o), .out_ch_o(out_ch_o), .out_valid_o(out_valid_o),
    .ovf_o(ovf_o), .ovf_clr_i(clr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: arbiter phase, pointer and expected registered outputs.
  int          m_phase = 0;
  int          m_ptr   = 3;
  int          m_sel   = 0;
  longint      m_data  = 0;
  int          m_sh    = 0;
  logic [31:0] m_out   = '0;
  int          m_ch    = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_ovf   = '0;
  logic [3:0]  m_ack   = '0;
  logic [3:0]  obs_ack = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    longint     s;
    logic [3:0] setv;
    int         sh;
    if (rst) begin
      m_phase = 0; m_ptr = 3; m_out = '0; m_ch = 0; m_valid = 1'b0; m_ovf = '0;
      return;
    end
    m_valid = 1'b0;
    setv    = '0;
    case (m_phase)
      0: if (req != 4'b0) begin
           for (int i = 1; i <= 4; i++) begin
             int c = (m_ptr + i) % 4;
             if (req[c]) begin m_sel = c; break; end
           end
           m_phase = 1;
         end
      1: if (req[m_sel]) begin
           m_data  = $signed(data[m_sel*64 +: 64]);
           sh      = int'(shift[m_sel*6 +: 6]);
           m_sh    = (sh > 32) ? 32 : sh;
           m_ptr   = m_sel;
           m_phase = 2;
         end else begin
           m_phase = 0;
         end
      default: begin
        s = m_data >>> m_sh;
        if (s > 64'sd2147483647) begin
          m_out = 32'h7FFF_FFFF; setv[m_sel] = 1'b1;
        end else if (s < -64'sd2147483648) begin
          m_out = 32'h8000_0000; setv[m_sel] = 1'b1;
        end else begin
          m_out = s[31:0];
        end
        m_ch = m_sel; m_valid = 1'b1; m_phase = 0;
      end
    endcase
    m_ovf = (m_ovf & ~clr) | setv;
  endtask

  // One clock: check registered outputs, then combinational ack, then advance model.
  task automatic step();
    logic [3:0] eack;
    check_eq("valid", 64'(out_valid_o), 64'(m_valid));
    check_eq("out", 64'(out_o), 64'(m_out));
    check_eq("out_ch", 64'(out_ch_o), 64'(m_ch));
    check_eq("ovf", 64'(ovf_o), 64'(m_ovf));
    #1;
    eack = (!rst && m_phase == 1 && req[m_sel]) ? 4'(1 << m_sel) : 4'b0;
    check_eq("ack", 64'(ack_o), 64'(eack));
    m_ack   = eack;
    obs_ack = ack_o;
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic serve(input int c, input logic [63:0] d, input logic [5:0] s,
                       input logic [31:0] eo, input logic eov);
    data[c*64 +: 64] = d;
    shift[c*6 +: 6]  = s;
    req[c] = 1'b1;
    step();
    step();
    check_eq("dir_ack", 64'(obs_ack), 64'(4'(1 << c)));
    req[c] = 1'b0;
    step();
    check_eq("dir_valid", 64'(out_valid_o), 64'd1);
    check_eq("dir_out", 64'(out_o), 64'(eo));
    check_eq("dir_ch", 64'(out_ch_o), 64'(c));
    check_eq("dir_ovf", 64'(ovf_o[c]), 64'(eov));
    step();
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom % 3)
      0:       return w;
      1:       return {{32{w[31]}}, w[31:0]};
      default: return {{24{w[39]}}, w[39:0]};
    endcase
  endfunction

  int ack_ch[$];
  int ack_cyc[$];

  initial begin
    rst = 1'b1; req = '0; data = '0; shift = '0; clr = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    serve(0, 64'h0000_0000_1234_5678, 6'd0, 32'h1234_5678, 1'b0);

    serve(1, 64'h0000_0001_0000_0000, 6'd0, 32'h7FFF_FFFF, 1'b1);
    serve(1, 64'h0000_0001_0000_0000, 6'd1, 32'h7FFF_FFFF, 1'b1);
    serve(1, 64'h0000_0001_0000_0000, 6'd2, 32'h4000_0000, 1'b1);
    clr = 4'b0010;
    step();
    clr = '0;
    check_eq("ovf1_clr", 64'(ovf_o[1]), 64'd0);
    step();

    serve(2, 64'hFFFF_FFFE_0000_0000, 6'd1, 32'h8000_0000, 1'b1);
    clr = 4'b0100;
    step();
    clr = '0;
    serve(2, 64'hFFFF_FFFE_0000_0000, 6'd2, 32'h8000_0000, 1'b0);
    serve(2, 64'hFFFF_FFFE_0000_0000, 6'd63, 32'hFFFF_FFFE, 1'b0);

    // Set/clear collision on ch3: clear pulsed in the cycle the overflow lands.
    data[192 +: 64] = 64'h7FFF_0000_0000_0000;
    shift[18 +: 6]  = 6'd0;
    req[3] = 1'b1;
    step();
    step();
    req[3] = 1'b0;
    clr = 4'b1000;
    step();
    clr = '0;
    check_eq("collide_ovf3", 64'(ovf_o[3]), 64'd1);
    step();

    // Fairness with all requests held after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) data[c*64 +: 64] = 64'(c + 100);
    req = 4'b1111;
    for (int k = 0; k < 18; k++) begin
      step();
      for (int c = 0; c < 4; c++) if (obs_ack[c]) begin ack_ch.push_back(c); ack_cyc.push_back(cyc); end
    end
    req = '0;
    check_eq("fair_count", 64'(ack_ch.size()), 64'd6);
    for (int k = 0; k < 6 && k < ack_ch.size(); k++) begin
      check_eq("fair_order", 64'(ack_ch[k]), 64'(k % 4));
      if (k > 0) check_eq("fair_space", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd3);
    end
    step(); step(); step();

    // Withdraw in CAP: no ack, pointer stays on ch1 so ch0 wins next over ch1.
    serve(1, 64'd5, 6'd0, 32'd5, 1'b0);
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    step();
    check_eq("abort_ack", 64'(obs_ack), 64'd0);
    step();
    step();
    check_eq("abort_valid", 64'(out_valid_o), 64'd0);
    req = 4'b0011;
    step();
    step();
    check_eq("abort_next_ack", 64'(obs_ack), 64'd1);
    req = '0;
    step(); step();

    // Reset during SAT discards the in-flight word.
    data[64 +: 64] = 64'h0000_0001_0000_0000;
    req[1] = 1'b1;
    step();
    step();
    req[1] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_out", 64'(out_o), 64'd0);
    check_eq("rst_ovf", 64'(ovf_o), 64'd0);
    step();
    check_eq("rst_valid2", 64'(out_valid_o), 64'd0);
    req = 4'b0011;
    step();
    step();
    check_eq("rst_next_ack", 64'(obs_ack), 64'd1);
    req = '0;
    step(); step();

    // Random traffic from four independent requesters.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (m_ack[c]) begin
          req[c] = 1'b0;
          if ($urandom % 2 == 0) begin
            data[c*64 +: 64] = rand_word();
            req[c] = 1'b1;
          end
        end else if (req[c]) begin
          if ($urandom % 50 == 0) req[c] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          data[c*64 +: 64] = rand_word();
          req[c] = 1'b1;
        end
      end
      if ($urandom % 20 == 0) shift[($urandom % 4)*6 +: 6] = 6'($urandom_range(0, 40));
      clr = ($urandom % 8 == 0) ? 4'($urandom) : 4'b0;
      rst = ($urandom % 400 == 0);
      if (rst) req = '0;
      step();
    end
    rst = 1'b0; req = '0; clr = '0;
    step(); step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lia_slice_scheduler.md
# lia_slice_scheduler

Time-shares one saturating slice/requantize stage among NCH wide (WIN-bit) result sources in the lock-in amplifier datapath: X, Y, and auxiliary accumulators/filters. Each source has its own programmable slice position (LSB shift). A round-robin arbiter grants one source at a time, captures its word, and arithmetic-shifts and saturates it to WOUT signed bits. It emits the result with a channel tag and valid strobe, and keeps per-channel sticky overflow flags.

## Interface
- NCH, 4, number of requesters (2..8)
- WIN, 64, input word width, signed two's complement
- WOUT, 32, output word width, signed
- SW, 6, per-channel shift field width; must hold WIN-WOUT
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- req_i  in  NCH  per-channel request; held with data until ack or withdrawn
- data_i  in  NCH*WIN  channel c at bits [c*WIN +: WIN]
- shift_i  in  NCH*SW  channel c slice LSB at [c*SW +: SW]; quasi-static
- ack_o  out  NCH  one-cycle pulse: channel word captured
- out_o  out  WOUT  saturated result
- out_ch_o  out  $clog2(NCH)  channel index of out_o
- out_valid_o  out  1  one-cycle strobe qualifying out_o/out_ch_o
- ovf_o  out  NCH  sticky overflow flag per channel
- ovf_clr_i  in  NCH  per-channel clear of ovf_o

## Operation
- FSM states: IDLE, CAP, SAT.
- IDLE: if any req_i is set, pick the winner `sel` by round-robin, searching from ptr+1 upward with wrap. Register `sel` and go to CAP; otherwise stay in IDLE.
- CAP with req_i[sel]=1:
  - pulse ack_o[sel];
  - latch data_i[sel] and eff_shift = min(shift_i[sel], WIN-WOUT);
  - set ptr <= sel;
  - go to SAT.
- CAP with req_i[sel]=0 (withdrawn): no ack, ptr unchanged, return to IDLE.
- SAT: s = latched_data >>> eff_shift (arithmetic, sign-extended). Register the result and go to IDLE.
  - s in [-2^(WOUT-1), 2^(WOUT-1)-1]: out_o <= s[WOUT-1:0].
  - s > max: out_o <= 0x7FFF_FFFF (WOUT=32); ovf set for sel.
  - s < min: out_o <= 0x8000_0000; ovf set for sel.
  - out_ch_o <= sel, out_valid_o <= 1 for one cycle.
- out_o and out_ch_o hold their value until the next result.
- ovf_o[c]: set by an overflow on c, cleared by ovf_clr_i[c]. If set and clear occur in the same cycle, set wins.
- shift_i is sampled only in CAP. Changes at other times do not affect an in-flight word.
- Reset (any state, including mid-operation):
  - state <= IDLE, ptr <= NCH-1 (channel 0 has first priority);
  - ack_o, out_o, out_ch_o, out_valid_o, ovf_o all 0;
  - an in-flight word is discarded with no out_valid_o.

## Timing
- req_i[c] seen in IDLE at cycle N: ack_o[c] in N+1, out_valid_o in N+3.
- The FSM is back in IDLE at N+3 and may arbitrate in that same cycle.
- Sustained throughput: one result per 3 cycles. With all NCH requests held, each channel is served once every 3*NCH cycles.
- A requester must hold data_i stable from req_i rise through its ack_o cycle, and deassert or present a new word the cycle after ack.
- ack_o is never asserted for more than one channel or more than one cycle per grant.
- out_valid_o is never asserted in consecutive cycles.

## Test plan
All scenarios use WIN=64, WOUT=32, NCH=4.
- Basic path: ch0 data 0x0000_0000_1234_5678, shift 0, req at N -> ack_o=0001 at N+1; out_valid at N+3 with out_o=0x1234_5678, out_ch_o=0, ovf_o=0.
- Positive saturation, ch1 data 0x0000_0001_0000_0000:
  - shift 0 -> 0x7FFF_FFFF, ovf_o[1]=1;
  - shift 1 -> 0x7FFF_FFFF;
  - shift 2 -> 0x4000_0000, no new set;
  - pulse ovf_clr_i[1] -> ovf_o[1]=0 next cycle.
- Negative boundary, ch2 data 0xFFFF_FFFE_0000_0000:
  - shift 1 -> 0x8000_0000 with ovf set;
  - shift 2 -> 0x8000_0000 with ovf clear;
  - shift 63 -> clamped to 32 -> 0xFFFF_FFFE.
- Fairness: req_i=1111 held continuously after reset -> ack order 0,1,2,3,0,1, spaced 3 cycles; out_ch_o follows the same order.
- Set/clear collision: overflow on ch3 in the same cycle ovf_clr_i[3]=1 -> ovf_o[3]=1.
- Abort/reset:
  - drop req_i[0] in its CAP cycle -> no ack, no out_valid, ptr unchanged;
  - assert rst_i during SAT -> no out_valid, all outputs 0; the next request wins from ch0.
